// File: rtl/button_debounce.sv
// Synchronises raw buttons and debounces them on sample_tick into level, press/release pulses and a key index.
// Latency: 2 clk sync + STABLE_SAMPLES ticks; no backpressure, pulses are single-cycle and never stall.
module button_debounce #(
  parameter int NUM_BTN        = 4,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic [NUM_BTN-1:0]         btn_raw,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic [NUM_BTN-1:0]         btn_press,
  output logic [NUM_BTN-1:0]         btn_release,
  output logic                       btn_valid,
  output logic [$clog2(NUM_BTN)-1:0] btn_code
);

  localparam int CW     = $clog2(STABLE_SAMPLES + 1);
  localparam int CODE_W = $clog2(NUM_BTN);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;
  logic [CW-1:0]      cnt [NUM_BTN];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1     <= '0;
      sync_q2     <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_q1     <= btn_raw;
      sync_q2     <= sync_q1;
      btn_press   <= '0;
      btn_release <= '0;
      if (sample_tick) begin
        for (int i = 0; i < NUM_BTN; i++) begin
          // Any matching sample restarts the run of differing samples.
          if (sync_q2[i] == btn_level[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            btn_level[i]   <= ~btn_level[i];
            btn_press[i]   <= ~btn_level[i];
            btn_release[i] <= btn_level[i];
            cnt[i]         <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign btn_valid = |btn_press;

  // Descending scan so the lowest pressed index wins.
  always_comb begin
    btn_code = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (btn_press[i]) begin
        btn_code = CODE_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: per-cycle vector table with tick held high, then tick-paced sequences.
module tb_button_debounce;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       btn_valid;
  logic [1:0] btn_code;

  int checks = 0;
  int errors = 0;

  button_debounce #(.NUM_BTN(4), .STABLE_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_valid(btn_valid), .btn_code(btn_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_v;
    logic       tick;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic       vld;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic t, logic [3:0] raw, logic [3:0] lvl,
                              logic [3:0] prs, logic [3:0] rel, logic vld, logic [1:0] code);
    vec_t v;
    v.rst_v = r; v.tick = t; v.raw = raw; v.lvl = lvl;
    v.prs = prs; v.rel = rel; v.vld = vld; v.code = code;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic vld, input logic [1:0] code);
    chk({name, ".level"},   32'(btn_level),   32'(lvl));
    chk({name, ".press"},   32'(btn_press),   32'(prs));
    chk({name, ".release"}, 32'(btn_release), 32'(rel));
    chk({name, ".valid"},   32'(btn_valid),   32'(vld));
    chk({name, ".code"},    32'(btn_code),    32'(code));
  endtask

  // Apply inputs away from the edge, clock once, sample just after the edge.
  task automatic cyc(input logic r, input logic t, input logic [3:0] raw);
    @(negedge clk);
    rst = r;
    sample_tick = t;
    btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  // Seven idle clocks let the synchroniser settle before the tick edge.
  task automatic do_tick(input logic [3:0] raw);
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, raw);
    cyc(1'b1, 1'b1, raw);
  endtask

  initial begin
    int gap_bad;
    rst = 1'b0;
    sample_tick = 1'b0;
    btn_raw = '0;

    // Tick held high: press lands 6 clk after the input edge.
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1, 2'd1));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 2'd0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 2'd0));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 2'd0));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0));
    // Simultaneous press of buttons 1 and 3.
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 1, 2'd1));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst_v, vecs[i].tick, vecs[i].raw);
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel,
              vecs[i].vld, vecs[i].code);
    end

    // Clean press then release of button 2, tick every 8 clk.
    cyc(1'b0, 1'b0, 4'b0000);
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      do_tick(4'b0100);
      chk_all($sformatf("press_t%0d", k), 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    do_tick(4'b0100);
    chk_all("press_t4", 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2);
    cyc(1'b1, 1'b0, 4'b0100);
    chk_all("press_after", 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      do_tick(4'b0000);
      chk_all($sformatf("rel_t%0d", k), 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    do_tick(4'b0000);
    chk_all("rel_t4", 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 4'b0000);
    chk_all("rel_after", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Bounce on button 0: samples 1,1,1,0,1,1,1,1.
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      for (int k = 0; k < 8; k++) begin
        do_tick({3'b000, pat[k]});
        chk($sformatf("bounce_t%0d.press", k + 1), 32'(btn_press), (k == 7) ? 32'h1 : 32'h0);
        chk($sformatf("bounce_t%0d.level", k + 1), 32'(btn_level), (k == 7) ? 32'h1 : 32'h0);
      end
    end

    // Reset while button 0 is held and debounced high.
    cyc(1'b0, 1'b0, 4'b0001);
    chk_all("midrst", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      do_tick(4'b0001);
      chk_all($sformatf("rearm_t%0d", k), 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    do_tick(4'b0001);
    chk_all("rearm_t4", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0);

    // Two differing samples, a 50 clk tick gap, then two more.
    do_tick(4'b0000);
    do_tick(4'b0000);
    chk_all("gap_pre", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
    gap_bad = 0;
    for (int k = 0; k < 50; k++) begin
      cyc(1'b1, 1'b0, 4'b0000);
      if (btn_level !== 4'b0001 || btn_release !== 4'b0000) gap_bad++;
    end
    chk("gap_hold_cycles", 32'(gap_bad), 32'd0);
    do_tick(4'b0000);
    chk_all("gap_t3", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
    do_tick(4'b0000);
    chk_all("gap_t4", 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Multi-input button conditioner for the digital lock front end. It synchronises raw push-button inputs and debounces them using the periodic single-cycle sample tick from the pulse generator. For each button it produces a clean level, a one-cycle press pulse and a one-cycle release pulse, plus an encoded key index that feeds the lock FSM.

## Interface
- NUM_BTN, 4, number of button inputs; must be ≥2.
- STABLE_SAMPLES, 4, number of consecutive differing samples required before the level changes; must be ≥1.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset; when 0 at a posedge, all state clears.
- sample_tick  input  1  one-cycle-wide debounce sample strobe from the pulse generator; may be held high continuously.
- btn_raw  input  NUM_BTN  asynchronous raw buttons, active-high.
- btn_level  output  NUM_BTN  debounced button levels.
- btn_press  output  NUM_BTN  one-cycle pulse on each debounced 0→1 transition.
- btn_release  output  NUM_BTN  one-cycle pulse on each debounced 1→0 transition.
- btn_valid  output  1  high when any btn_press bit is high.
- btn_code  output  $clog2(NUM_BTN)  index of the lowest-numbered btn_press bit that is high; 0 when btn_valid=0.

## Operation
- Synchroniser:
  - Each btn_raw bit passes through two flops, clocked every clk regardless of sample_tick.
  - Both flop stages reset to 0.
  - sync[i] is the second stage.
- Per-button state: cnt[i], width $clog2(STABLE_SAMPLES+1), reset 0; and btn_level[i], reset 0.
- On a posedge with rst=1 and sample_tick=1, for each button:
  - sync[i]==btn_level[i]: cnt[i] <= 0.
  - sync[i]!=btn_level[i] and cnt[i]==STABLE_SAMPLES-1:
    - btn_level[i] toggles and cnt[i] <= 0.
    - If the new level is 1, btn_press[i] <= 1.
    - If the new level is 0, btn_release[i] <= 1.
  - Otherwise: cnt[i] <= cnt[i]+1.
- btn_press and btn_release are registers.
  - They are 0 on every edge where their level does not flip, so each pulse is exactly one clk wide.
  - They assert in the same cycle btn_level first shows the new value.
- sample_tick=0: cnt and btn_level hold; press and release go to 0.
- Any sample that matches the current level restarts the count. A bounce therefore requires STABLE_SAMPLES fresh consecutive differing samples.
- STABLE_SAMPLES=1: the level follows sync on the first differing sample.
- btn_valid and btn_code are combinational from the btn_press register. Simultaneous presses report the lowest index; all set bits stay visible in btn_press.
- Counters saturate by construction: they clear on a flip or a match and never exceed STABLE_SAMPLES-1.

## Timing
- Reset values: btn_level=0, btn_press=0, btn_release=0, btn_valid=0, btn_code=0. Synchroniser and all counters are 0.
- Reset mid-operation clears everything at the next posedge with rst=0.
- After reset deasserts:
  - A button still held produces a normal press after STABLE_SAMPLES ticks.
  - No release pulse is generated for a button that was pressed before reset.
- Latency from a btn_raw edge to sync: 2 clk.
- Latency from a btn_raw edge to btn_level/btn_press: 2 clk plus the time until the STABLE_SAMPLES-th subsequent sample_tick edge that sees the new value.
  - With sample_tick held high, this is 2+STABLE_SAMPLES clk.
- Simultaneous events:
  - Independent buttons flip independently on the same edge.
  - A button's press and release can never coincide.
- sample_tick coinciding with rst=0: reset wins.

## Test plan
- Clean press, then release:
  - Stimulus: NUM_BTN=4, STABLE_SAMPLES=4, tick every 8 clk; hold btn_raw[2]=1 for 60 clk, then set it to 0.
  - Required response: btn_level[2] rises on the 4th tick after sync goes high, with btn_press[2] high for 1 clk, btn_valid=1 and btn_code=2. btn_release[2] pulses once after 4 further ticks.
- Bounce rejection:
  - Stimulus: btn_raw[0] toggles so sync shows 1,1,1,0,1,1,1,1 on successive ticks.
  - Required response: no press after the first three ones. Exactly one press on the 8th tick (the 4th consecutive one).
- Simultaneous press:
  - Stimulus: btn_raw[1] and btn_raw[3] rise on the same clk.
  - Required response: btn_press=4'b1010 for 1 clk, btn_valid=1, btn_code=1.
- Reset mid-press:
  - Stimulus: with btn_level[0]=1, pulse rst=0 for 1 clk while btn_raw[0] stays 1.
  - Required response: all outputs 0 on the next cycle; no btn_release. btn_press[0] reasserts after 4 ticks.
- Tick held high:
  - Stimulus: sample_tick=1 constantly, STABLE_SAMPLES=4; step btn_raw[1] 0→1.
  - Required response: btn_press[1] is high exactly 6 clk after the input edge, for 1 clk.
- Tick gap hold:
  - Stimulus: present 2 differing samples, then drop sample_tick for 50 clk, then resume.
  - Required response: counts resume. The flip occurs after 2 more differing ticks, and no flip occurs during the gap.
